sar_ctrl: RTL

Successive-approximation controller for the mixed-signal ADC path. It runs on the 3.2 MHz digital clock `oclk` and starts converting once `en` is asserted. Each conversion has a track phase, then bit-by-bit trial codes for the capacitive DAC. It reads the comparator decision once per bit and outputs the resolved code with a one-cycle valid strobe. It sits directly downstream of the clock/reset/enable source and upstream of the digital sample consumer.

---
 rtl/sar_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/sar_ctrl.sv
// sar_ctrl: successive-approximation ADC controller; SAR_CTRL_AVG4_EN adds 4-sample output averaging.
module sar_ctrl #(
  parameter int N             = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic         oclk,
  input  logic         rst,
  input  logic         en,
  input  logic         cmp,
  output logic         sample,
  output logic         cmp_en,
  output logic [N-1:0] dac_code,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  output logic         busy
);
  localparam int KW = $clog2(N);
  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;
  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [KW-1:0]  k_q, k_d;
  logic [N-1:0]   res_q, res_d;
  logic [N-1:0]   dout_q, dout_d;
  logic           valid_q, valid_d;
  logic           last_sample;
`ifdef SAR_CTRL_AVG4_EN
  logic [N+1:0]   acc_q, acc_d, sum;
  logic [1:0]     grp_q, grp_d;
  logic           group_end;
`endif
  assign last_sample = cnt_q == 4'(SAMPLE_CYCLES - 1);
  always_ff @(posedge oclk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      res_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
`ifdef SAR_CTRL_AVG4_EN
      acc_q   <= '0;
      grp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
`ifdef SAR_CTRL_AVG4_EN
      acc_q   <= acc_d;
      grp_q   <= grp_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q == IDLE   ? (en ? SAMPLE : IDLE)
            : state_q == SAMPLE ? (last_sample ? CONV : SAMPLE)
            : state_q == CONV   ? (k_q == '0 ? DONE : CONV)
            : (en ? SAMPLE : IDLE);
  end
  // The resolved register is cleared while tracking so trial codes start from zero.
  always_comb begin
    cnt_d = (state_q == SAMPLE && !last_sample) ? cnt_q + 4'd1 : '0;
    k_d   = state_q == SAMPLE ? KW'(N - 1)
          : (state_q == CONV && k_q != '0) ? k_q - KW'(1) : '0;
    res_d = state_q == SAMPLE ? '0 : res_q;
    if (state_q == CONV) res_d[k_q] = cmp;
`ifdef SAR_CTRL_AVG4_EN
    sum       = acc_q + {2'b00, res_q};
    group_end = state_q == DONE && grp_q == 2'd3;
    acc_d     = state_q == DONE ? (group_end ? '0 : sum) : acc_q;
    grp_d     = state_q == DONE ? grp_q + 2'd1 : grp_q;
    dout_d    = group_end ? sum[N+1:2] : dout_q;
    valid_d   = group_end;
`else
    dout_d    = state_q == DONE ? res_q : dout_q;
    valid_d   = state_q == DONE;
`endif
  end
  always_comb begin
    sample     = state_q == SAMPLE;
    cmp_en     = state_q == CONV;
    dac_code   = state_q == CONV ? res_q | (N'(1) << k_q) : '0;
    busy       = state_q != IDLE;
    dout       = dout_q;
    dout_valid = valid_q;
  end
endmodule
